// File: rtl/adder_tree_accum.sv
// Pipelined pairwise adder tree over NUM_INPUTS signed lanes, followed by an
// accumulator that folds NUM_BEATS consecutive tree sums into one registered result.
module adder_tree_accum #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_INPUTS = 9,
  parameter int unsigned NUM_BEATS  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_valid,
  input  logic [DATA_WIDTH*NUM_INPUTS-1:0] i_data,
  output logic                             o_valid,
  output logic [DATA_WIDTH-1:0]            o_data
);

  // Lane count entering a given layer: each layer halves, rounding up.
  function automatic int unsigned lanes_at(input int unsigned layer);
    int unsigned n;
    n = NUM_INPUTS;
    for (int unsigned l = 0; l < layer; l++) begin
      n = (n - 1) / 2 + 1;
    end
    return n;
  endfunction

  localparam int unsigned Depth = (NUM_INPUTS <= 1) ? 1 : $clog2(NUM_INPUTS);
  localparam int unsigned CntW  = (NUM_BEATS <= 1) ? 1 : $clog2(NUM_BEATS);
  localparam logic [CntW-1:0] CntLast = CntW'(NUM_BEATS - 1);

  for (genvar j = 0; j < Depth; j++) begin : g_layer
    localparam int unsigned NIn  = lanes_at(j);
    localparam int unsigned NOut = lanes_at(j + 1);

    logic [DATA_WIDTH-1:0] w_in  [NIn];
    logic [DATA_WIDTH-1:0] w_nxt [NOut];
    logic [DATA_WIDTH-1:0] r_sum [NOut];
    logic                  w_vld_in;
    logic                  r_vld;

    if (j == 0) begin : g_src
      assign w_vld_in = i_valid;
      for (genvar k = 0; k < NIn; k++) begin : g_lane
        assign w_in[k] = i_data[DATA_WIDTH*k +: DATA_WIDTH];
      end
    end else begin : g_src
      assign w_vld_in = g_layer[j-1].r_vld;
      for (genvar k = 0; k < NIn; k++) begin : g_lane
        assign w_in[k] = g_layer[j-1].r_sum[k];
      end
    end

    // An odd trailing lane passes through; a single-lane tree is a plain register.
    for (genvar i = 0; i < NOut; i++) begin : g_node
      if (2 * i + 1 < NIn) begin : g_add
        assign w_nxt[i] = w_in[2*i] + w_in[2*i+1];
      end else begin : g_pass
        assign w_nxt[i] = w_in[2*i];
      end
    end

    always_ff @(posedge clk) begin
      r_sum <= w_nxt;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_vld <= 1'b0;
      end else begin
        r_vld <= w_vld_in;
      end
    end
  end

  logic [DATA_WIDTH-1:0] w_tree_sum;
  logic                  w_tree_vld;
  logic [DATA_WIDTH-1:0] w_acc_nxt;

  assign w_tree_sum = g_layer[Depth-1].r_sum[0];
  assign w_tree_vld = g_layer[Depth-1].r_vld;

  logic [CntW-1:0]       r_cnt;
  logic [DATA_WIDTH-1:0] r_acc;
  logic                  r_out_vld;
  logic [DATA_WIDTH-1:0] r_out;

  // First beat of a group overwrites the accumulator rather than adding to it.
  always_comb begin
    w_acc_nxt = w_tree_sum;
    if (r_cnt != '0) begin
      w_acc_nxt = r_acc + w_tree_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_out_vld <= 1'b0;
      r_out     <= '0;
    end else begin
      r_out_vld <= 1'b0;
      if (w_tree_vld) begin
        r_acc <= w_acc_nxt;
        if (r_cnt == CntLast) begin
          r_cnt     <= '0;
          r_out_vld <= 1'b1;
          r_out     <= w_acc_nxt;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_valid = r_out_vld;
  assign o_data  = r_out;

endmodule

// File: tb/tb_adder_tree_accum.sv
// Drives several adder_tree_accum configurations with shared stimulus and checks each
// against a queue-based group-sum model, plus literal expectations for directed cases.
module tb_adder_tree_accum;

  localparam int unsigned W    = 16;
  localparam int unsigned NCFG = 7;
  localparam int unsigned MAXL = 16;
  localparam int unsigned CFG_NI [NCFG] = '{9, 9, 1, 2, 3, 5, 16};
  localparam int unsigned CFG_NB [NCFG] = '{4, 1, 1, 1, 1, 1, 1};

  // Edges between the sampling edge of a group's last beat and the edge that
  // raises o_valid; the pulse is visible in the D+1-th cycle counting the sampling one.
  localparam int CFG_LAT [NCFG] = '{4, 4, 1, 1, 2, 3, 4};

  typedef struct {
    longint          due;
    logic [W-1:0]    val;
  } exp_t;

  logic             clk     = 1'b0;
  logic             rst     = 1'b1;
  logic             i_valid = 1'b0;
  logic [W-1:0]     lanes [MAXL];
  logic [W*MAXL-1:0] flat;

  logic             dut_vld [NCFG];
  logic [W-1:0]     dut_dat [NCFG];

  always #5 clk = ~clk;

  for (genvar k = 0; k < MAXL; k++) begin : g_pack
    assign flat[W*k +: W] = lanes[k];
  end

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    adder_tree_accum #(
      .DATA_WIDTH(W),
      .NUM_INPUTS(CFG_NI[g]),
      .NUM_BEATS (CFG_NB[g])
    ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .i_valid(i_valid),
      .i_data (flat[W*CFG_NI[g]-1:0]),
      .o_valid(dut_vld[g]),
      .o_data (dut_dat[g])
    );
  end

  // ---------------- behavioural model ----------------
  exp_t         pend [NCFG][$];
  exp_t         plog [NCFG][$];
  logic [W-1:0] grp_acc [NCFG];
  int           grp_cnt [NCFG];
  logic         exp_vld [NCFG];
  logic [W-1:0] exp_dat [NCFG];
  longint       edge_n = 0;
  longint       last_edge = 0;
  int           n_chk = 0;
  int           n_pass = 0;

  function automatic int tree_depth(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  always @(posedge clk) begin
    logic [W-1:0] s;
    exp_t         e;
    edge_n++;
    for (int c = 0; c < NCFG; c++) begin
      exp_vld[c] = 1'b0;
      if (rst) begin
        pend[c].delete();
        grp_acc[c] = '0;
        grp_cnt[c] = 0;
        exp_dat[c] = '0;
      end else begin
        if (pend[c].size() > 0 && pend[c][0].due == edge_n) begin
          exp_vld[c] = 1'b1;
          exp_dat[c] = pend[c][0].val;
          void'(pend[c].pop_front());
        end
        if (i_valid) begin
          s = '0;
          for (int k = 0; k < int'(CFG_NI[c]); k++) s = s + lanes[k];
          grp_acc[c] = grp_acc[c] + s;
          grp_cnt[c]++;
          if (grp_cnt[c] == int'(CFG_NB[c])) begin
            e.due = edge_n + longint'(tree_depth(CFG_NI[c]));
            e.val = grp_acc[c];
            pend[c].push_back(e);
            grp_acc[c] = '0;
            grp_cnt[c] = 0;
          end
        end
      end
    end
  end

  // Per-cycle comparison and pulse logging, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    for (int c = 0; c < NCFG; c++) begin
      n_chk++;
      if (dut_vld[c] === exp_vld[c]) n_pass++;
      else $display("FAIL o_valid cfg%0d edge %0d: got %b want %b", c, edge_n, dut_vld[c],
                    exp_vld[c]);
      n_chk++;
      if (dut_dat[c] === exp_dat[c]) n_pass++;
      else $display("FAIL o_data cfg%0d edge %0d: got %h want %h", c, edge_n, dut_dat[c],
                    exp_dat[c]);
      if (dut_vld[c] === 1'b1) begin
        e.due = edge_n;
        e.val = dut_dat[c];
        plog[c].push_back(e);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic check(input string nm, input longint got, input longint want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, got, want);
  endtask

  task automatic set_all(input logic [W-1:0] v);
    for (int k = 0; k < MAXL; k++) lanes[k] = v;
  endtask

  task automatic beat();
    i_valid = 1'b1;
    @(posedge clk);
    #1;
    last_edge = edge_n;
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    for (int c = 0; c < NCFG; c++) plog[c].delete();
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    i_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("reset o_valid", longint'(dut_vld[0]), 0);
    check("reset o_data", longint'(dut_dat[0]), 0);
  endtask

  task automatic check_last(input string nm, input int c, input int want_n,
                            input longint want_val);
    check({nm, " count"}, plog[c].size(), want_n);
    if (plog[c].size() > 0) begin
      check({nm, " value"}, longint'(plog[c][plog[c].size()-1].val), want_val);
      check({nm, " latency"}, plog[c][plog[c].size()-1].due - last_edge, CFG_LAT[c]);
    end
  endtask

  localparam longint ONES_SUM [NCFG] = '{36, 9, 1, 2, 3, 5, 16};

  initial begin
    set_all('0);
    idle(3);
    rst = 1'b0;

    // All lanes 1, four back-to-back beats.
    do_reset();
    clear_logs();
    set_all(16'd1);
    repeat (4) beat();
    idle(10);
    for (int c = 0; c < NCFG; c++) begin
      check_last($sformatf("ones cfg%0d", c), c, (c == 0) ? 1 : 4, ONES_SUM[c]);
    end

    // Lanes carry their index.
    do_reset();
    clear_logs();
    for (int k = 0; k < MAXL; k++) lanes[k] = W'(k);
    repeat (4) beat();
    idle(10);
    check_last("index", 0, 1, 144);

    // Signed wrap with a single-beat group.
    do_reset();
    clear_logs();
    set_all(16'h7FFF);
    beat();
    idle(10);
    check_last("wrap", 1, 1, 64'h7FF7);

    // Alternating -3 / +1, lane 8 = -3.
    do_reset();
    clear_logs();
    for (int k = 0; k < MAXL; k++) lanes[k] = (k % 2 == 0) ? 16'hFFFD : 16'h0001;
    repeat (4) beat();
    idle(10);
    check_last("alternating", 0, 1, 64'hFFD4);

    // Gaps of 0, 3 and 7 idle cycles.
    do_reset();
    clear_logs();
    set_all(16'd2);
    beat();
    beat();
    idle(3);
    beat();
    idle(7);
    beat();
    idle(10);
    check_last("gapped", 0, 1, 72);

    // Reset with a third beat in flight; a beat offered during reset is ignored.
    do_reset();
    clear_logs();
    set_all(16'd1);
    repeat (3) beat();
    rst     = 1'b1;
    set_all(16'd5);
    i_valid = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    i_valid = 1'b0;
    check("midreset o_valid", longint'(dut_vld[0]), 0);
    check("midreset o_data", longint'(dut_dat[0]), 0);
    set_all(16'd1);
    repeat (4) beat();
    idle(10);
    check_last("midreset", 0, 1, 36);

    // Twelve back-to-back beats of value b = 1..12.
    do_reset();
    clear_logs();
    for (int b = 1; b <= 12; b++) begin
      set_all(W'(b));
      beat();
    end
    idle(10);
    check("b2b count", plog[0].size(), 3);
    if (plog[0].size() == 3) begin
      check("b2b value0", longint'(plog[0][0].val), 90);
      check("b2b value1", longint'(plog[0][1].val), 234);
      check("b2b value2", longint'(plog[0][2].val), 378);
      check("b2b spacing0", plog[0][1].due - plog[0][0].due, 4);
      check("b2b spacing1", plog[0][2].due - plog[0][1].due, 4);
    end

    // Random stream: full-rate first, then random valid and sporadic reset.
    do_reset();
    for (int t = 0; t < 400; t++) begin
      for (int k = 0; k < MAXL; k++) lanes[k] = W'($urandom);
      i_valid = (t < 200) ? 1'b1 : ($urandom_range(0, 3) != 0);
      rst     = (t >= 200) && ($urandom_range(0, 49) == 0);
      @(negedge clk);
    end
    rst     = 1'b0;
    i_valid = 1'b0;
    idle(10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
